bcd_conv_arb: RTL and testbench

- Iterative (shift-add-3, double-dabble) binary-to-BCD engine, one shift per clock, shared by two requesters.
- Round-robin arbitration picks the requester; an FSM sequences the conversion; digits are returned with a done pulse tagged by requester id.
- Feeds the 7-segment digit/scan logic.
- Replaces per-requester combinational converters where area matters more than latency.

---
 rtl/bcd_conv_arb_if.sv | 40 ++++
 rtl/bcd_conv_arb.sv | 146 ++++++++++++++
 tb/tb_bcd_conv_arb.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_conv_arb_if.sv
// Request/grant/result bundle for the shared binary-to-BCD converter.
// BCD_CONV_ARB_BLANK_EN adds the leading-zero blanking flags.
interface bcd_conv_arb_if #(
  parameter int unsigned DW = 8
) ();
  logic          req0;
  logic [DW-1:0] in0;
  logic          req1;
  logic [DW-1:0] in1;
  logic          gnt0;
  logic          gnt1;
  logic          busy;
  logic          done;
  logic          done_id;
  logic [3:0]    units;
  logic [3:0]    tens;
  logic [1:0]    hunds;
`ifdef BCD_CONV_ARB_BLANK_EN
  logic          blank_hunds;
  logic          blank_tens;

  modport master (
    output req0, in0, req1, in1,
    input  gnt0, gnt1, busy, done, done_id, units, tens, hunds, blank_hunds, blank_tens
  );
  modport slave (
    input  req0, in0, req1, in1,
    output gnt0, gnt1, busy, done, done_id, units, tens, hunds, blank_hunds, blank_tens
  );
`else
  modport master (
    output req0, in0, req1, in1,
    input  gnt0, gnt1, busy, done, done_id, units, tens, hunds
  );
  modport slave (
    input  req0, in0, req1, in1,
    output gnt0, gnt1, busy, done, done_id, units, tens, hunds
  );
`endif
endinterface

// File: rtl/bcd_conv_arb.sv
// Round-robin shared double-dabble binary-to-BCD converter, one shift per clock.
// Optional macro BCD_CONV_ARB_BLANK_EN adds registered leading-zero blank flags.
module bcd_conv_arb #(
  parameter int unsigned DW = 8
) (
  input  logic           clk,
  input  logic           rst,
  bcd_conv_arb_if.slave  bus
);

  localparam int unsigned SW = DW + 10;
  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;
  localparam int unsigned UL = DW;
  localparam int unsigned TL = DW + 4;
  localparam int unsigned HL = DW + 8;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] sr_q, sr_d, sr_adj, sr_shl;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          busy_q, busy_d, done_q, done_d, done_id_q, done_id_d;
  logic [3:0]    units_q, units_d, tens_q, tens_d;
  logic [1:0]    hunds_q, hunds_d;
`ifdef BCD_CONV_ARB_BLANK_EN
  logic          blank_hunds_q, blank_hunds_d, blank_tens_q, blank_tens_d;
`endif

  // Add-3 correction then shift; the 2-bit hundreds field never reaches 5 for DW<=8.
  always_comb begin
    sr_adj = sr_q;
    if (sr_q[UL +: 4] >= 4'd5) sr_adj[UL +: 4] = sr_q[UL +: 4] + 4'd3;
    if (sr_q[TL +: 4] >= 4'd5) sr_adj[TL +: 4] = sr_q[TL +: 4] + 4'd3;
    sr_shl = {sr_adj[SW-2:0], 1'b0};
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    units_d   = units_q;
    tens_d    = tens_q;
    hunds_d   = hunds_q;
`ifdef BCD_CONV_ARB_BLANK_EN
    blank_hunds_d = blank_hunds_q;
    blank_tens_d  = blank_tens_q;
`endif
    unique case (state_q)
      IDLE: begin
        // On a tie the requester that was not served last wins.
        if (bus.req0 && (!bus.req1 || last_q)) begin
          sr_d    = SW'(bus.in0);
          cnt_d   = '0;
          last_d  = 1'b0;
          gnt0_d  = 1'b1;
          state_d = SHIFT;
        end else if (bus.req1) begin
          sr_d    = SW'(bus.in1);
          cnt_d   = '0;
          last_d  = 1'b1;
          gnt1_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d = sr_shl;
        if (cnt_q == CW'(DW - 1)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          done_id_d = last_q;
          units_d   = sr_shl[UL +: 4];
          tens_d    = sr_shl[TL +: 4];
          hunds_d   = sr_shl[HL +: 2];
`ifdef BCD_CONV_ARB_BLANK_EN
          blank_hunds_d = (sr_shl[HL +: 2] == 2'd0);
          blank_tens_d  = (sr_shl[HL +: 2] == 2'd0) && (sr_shl[TL +: 4] == 4'd0);
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      units_q   <= '0;
      tens_q    <= '0;
      hunds_q   <= '0;
`ifdef BCD_CONV_ARB_BLANK_EN
      blank_hunds_q <= 1'b0;
      blank_tens_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      units_q   <= units_d;
      tens_q    <= tens_d;
      hunds_q   <= hunds_d;
`ifdef BCD_CONV_ARB_BLANK_EN
      blank_hunds_q <= blank_hunds_d;
      blank_tens_q  <= blank_tens_d;
`endif
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.units   = units_q;
  assign bus.tens    = tens_q;
  assign bus.hunds   = hunds_q;
`ifdef BCD_CONV_ARB_BLANK_EN
  assign bus.blank_hunds = blank_hunds_q;
  assign bus.blank_tens  = blank_tens_q;
`endif

endmodule

// File: tb/tb_bcd_conv_arb.sv
// Bench for bcd_conv_arb: randomized and directed requests against a decimal model.
module tb_bcd_conv_arb;
  localparam int unsigned DW = 8;
  localparam int DONE_K = DW + 1;

  typedef struct {
    int         gk;
    int         dk;
    int         nbusy;
    int         ngnt;
    bit         did;
    bit         busy_after;
    logic [9:0] dig;
    logic [1:0] blank;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   last_m;

  bcd_conv_arb_if #(.DW(DW)) bus ();
  bcd_conv_arb #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Decimal reference: {hunds, tens, units} from plain division.
  function automatic logic [9:0] ref_bcd(input int v);
    return {2'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [1:0] ref_blank(input logic [9:0] d);
    return {d[9:8] == 2'd0, (d[9:8] == 2'd0) && (d[7:4] == 4'd0)};
  endfunction

  function automatic logic [1:0] get_blank();
`ifdef BCD_CONV_ARB_BLANK_EN
    return {bus.blank_hunds, bus.blank_tens};
`else
    return 2'b00;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_m = 1'b1;
  endtask

  // Single request; returns observed timing (k=1 is the cycle after the request is sampled).
  task automatic convert(input bit id, input logic [7:0] val, output res_t r);
    r.gk = -1; r.dk = -1; r.nbusy = 0; r.ngnt = 0; r.did = 1'b0; r.dig = 'x; r.blank = 'x;
    if (id) begin bus.req1 = 1'b1; bus.in1 = val; end
    else    begin bus.req0 = 1'b1; bus.in0 = val; end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.busy) r.nbusy++;
      if (bus.gnt0 || bus.gnt1) r.ngnt++;
      if (r.gk < 0 && (id ? bus.gnt1 : bus.gnt0)) begin
        r.gk = k;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
      end
      if (bus.done) begin
        r.dk = k; r.did = bus.done_id;
        r.dig = {bus.hunds, bus.tens, bus.units};
        r.blank = get_blank();
        break;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    r.busy_after = bus.busy;
    last_m = id;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus.busy, bus.gnt0, bus.gnt1, bus.done, bus.done_id} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl got %b expected 00000", {bus.busy, bus.gnt0, bus.gnt1, bus.done, bus.done_id});
    end
    n_cmp++;
    if ({bus.hunds, bus.tens, bus.units, get_blank()} !== 12'h0) begin
      n_err++; $display("FAIL reset_digits got %h expected 000", {bus.hunds, bus.tens, bus.units, get_blank()});
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_err++; $display("FAIL reset_idle got %b expected 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_single_255();
    res_t r;
    convert(1'b0, 8'd255, r);
    n_cmp++; if (r.gk !== 1) begin n_err++; $display("FAIL max_gnt_lat got %0d expected 1", r.gk); end
    n_cmp++; if (r.dk !== DONE_K) begin n_err++; $display("FAIL max_done_lat got %0d expected %0d", r.dk, DONE_K); end
    n_cmp++; if (r.dig !== ref_bcd(255)) begin n_err++; $display("FAIL max_digits got %h expected %h", r.dig, ref_bcd(255)); end
    n_cmp++; if (r.did !== 1'b0) begin n_err++; $display("FAIL max_id got %0d expected 0", r.did); end
    n_cmp++; if (r.nbusy !== DONE_K) begin n_err++; $display("FAIL max_busy_cycles got %0d expected %0d", r.nbusy, DONE_K); end
    n_cmp++; if (r.busy_after !== 1'b0) begin n_err++; $display("FAIL max_busy_after got %0d expected 0", r.busy_after); end
    n_cmp++; if (r.ngnt !== 1) begin n_err++; $display("FAIL max_gnt_width got %0d expected 1", r.ngnt); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.hunds, bus.tens, bus.units} !== ref_bcd(255)) begin
      n_err++; $display("FAIL max_hold got %h expected %h", {bus.hunds, bus.tens, bus.units}, ref_bcd(255));
    end
  endtask

  task automatic test_boundaries();
    res_t r;
    int   vals[3] = '{0, 9, 10};
    bit   ids[3]  = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      convert(ids[i], 8'(vals[i]), r);
      n_cmp++;
      if ({r.did, r.dig} !== {ids[i], ref_bcd(vals[i])}) begin
        n_err++; $display("FAIL bound_%0d got id%0d %h expected id%0d %h", vals[i], r.did, r.dig, ids[i], ref_bcd(vals[i]));
      end
`ifdef BCD_CONV_ARB_BLANK_EN
      n_cmp++;
      if (r.blank !== ref_blank(ref_bcd(vals[i]))) begin
        n_err++; $display("FAIL blank_%0d got %b expected %b", vals[i], r.blank, ref_blank(ref_bcd(vals[i])));
      end
`endif
    end
  endtask

  task automatic test_random();
    res_t r;
    for (int i = 0; i < 16; i++) begin
      bit id = 1'($urandom_range(0, 1));
      int v  = int'($urandom_range(0, 255));
      convert(id, 8'(v), r);
      n_cmp++;
      if ({r.gk, r.dk} !== {32'sd1, 32'(DONE_K)}) begin
        n_err++; $display("FAIL rand_lat v=%0d got gnt %0d done %0d expected 1 %0d", v, r.gk, r.dk, DONE_K);
      end
      n_cmp++;
      if ({r.did, r.dig, r.blank} !== {id, ref_bcd(v), get_blank_exp(ref_bcd(v))}) begin
        n_err++; $display("FAIL rand_result v=%0d got id%0d %h/%b expected id%0d %h/%b", v, r.did, r.dig, r.blank, id, ref_bcd(v), get_blank_exp(ref_bcd(v)));
      end
    end
  endtask

  function automatic logic [1:0] get_blank_exp(input logic [9:0] d);
`ifdef BCD_CONV_ARB_BLANK_EN
    return ref_blank(d);
`else
    return 2'b00;
`endif
  endfunction

  // Both requesters raised together; the one not served last goes first.
  task automatic tie_round(input logic [7:0] v0, input logic [7:0] v1);
    bit         first;
    int         dk[2] = '{-1, -1};
    bit         ids[2] = '{1'b0, 1'b0};
    logic [9:0] dg[2];
    int         nd = 0, ng = 0, g2 = -1;
    first = ~last_m;
    bus.req0 = 1'b1; bus.in0 = v0; bus.req1 = 1'b1; bus.in1 = v1;
    for (int k = 1; k <= 60 && nd < 2; k++) begin
      @(negedge clk);
      if (bus.gnt0) begin bus.req0 = 1'b0; ng++; if (ng == 2) g2 = k; end
      if (bus.gnt1) begin bus.req1 = 1'b0; ng++; if (ng == 2) g2 = k; end
      if (bus.done) begin
        dk[nd] = k; ids[nd] = bus.done_id; dg[nd] = {bus.hunds, bus.tens, bus.units}; nd++;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    n_cmp++; if (nd !== 2) begin n_err++; $display("FAIL tie_count got %0d expected 2", nd); end
    n_cmp++;
    if ({ids[0], ids[1]} !== {first, ~first}) begin
      n_err++; $display("FAIL tie_order got %0d,%0d expected %0d,%0d", ids[0], ids[1], first, ~first);
    end
    n_cmp++;
    if ({dg[0], dg[1]} !== {ref_bcd(first ? v1 : v0), ref_bcd(first ? v0 : v1)}) begin
      n_err++; $display("FAIL tie_digits got %h,%h expected %h,%h", dg[0], dg[1], ref_bcd(first ? v1 : v0), ref_bcd(first ? v0 : v1));
    end
    n_cmp++;
    if ({dk[0], dk[1], g2} !== {32'(DONE_K), 32'(2 * DW + 3), 32'(DW + 3)}) begin
      n_err++; $display("FAIL tie_timing got done %0d,%0d gnt2 %0d expected %0d,%0d gnt2 %0d", dk[0], dk[1], g2, DONE_K, 2 * DW + 3, DW + 3);
    end
    last_m = ~first;
  endtask

  task automatic test_back_to_back();
    res_t r;
    do_reset();
    tie_round(8'd123, 8'd45);
    tie_round(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    convert(1'b0, 8'($urandom_range(0, 255)), r);
    tie_round(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  task automatic test_midshift();
    int         g1 = -1, early = 0, dk = -1;
    logic [9:0] dg;
    logic [7:0] v0, v1;
    v0 = 8'($urandom_range(0, 255)); v1 = 8'($urandom_range(0, 255));
    bus.req0 = 1'b1; bus.in0 = v0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.gnt0) bus.req0 = 1'b0;
      if (k == 3) begin bus.req1 = 1'b1; bus.in1 = v1; end
      if (bus.gnt1 && g1 < 0) begin g1 = k; bus.req1 = 1'b0; end
      if (bus.gnt1 && k < DW + 3) early++;
      if (bus.done && bus.done_id) begin dk = k; dg = {bus.hunds, bus.tens, bus.units}; break; end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    last_m = 1'b1;
    n_cmp++; if (early !== 0) begin n_err++; $display("FAIL mid_early_gnt got %0d expected 0", early); end
    n_cmp++; if (g1 !== DW + 3) begin n_err++; $display("FAIL mid_gnt1 got %0d expected %0d", g1, DW + 3); end
    n_cmp++;
    if ({dk, dg} !== {32'(2 * DW + 3), ref_bcd(v1)}) begin
      n_err++; $display("FAIL mid_result got %0d %h expected %0d %h", dk, dg, 2 * DW + 3, ref_bcd(v1));
    end
  endtask

  task automatic test_rst_abort();
    res_t r;
    int   nd = 0;
    bus.req0 = 1'b1; bus.in0 = 8'd77;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (bus.gnt0) bus.req0 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.gnt0, bus.gnt1, bus.done, bus.done_id, bus.hunds, bus.tens, bus.units, get_blank()} !== 17'h0) begin
      n_err++; $display("FAIL abort_clear got %b %h expected all zero", {bus.busy, bus.gnt0, bus.gnt1, bus.done, bus.done_id}, {bus.hunds, bus.tens, bus.units});
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) nd++;
    end
    n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL abort_no_done got %0d expected 0", nd); end
    last_m = 1'b1;
    convert(1'b0, 8'd200, r);
    n_cmp++;
    if ({r.gk, r.dk, r.did, r.dig} !== {32'sd1, 32'(DONE_K), 1'b0, ref_bcd(200)}) begin
      n_err++; $display("FAIL abort_retry got %0d %0d id%0d %h expected 1 %0d id0 %h", r.gk, r.dk, r.did, r.dig, DONE_K, ref_bcd(200));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.in0 = '0; bus.in1 = '0;
    test_reset();
    test_single_255();
    test_boundaries();
    test_random();
    test_back_to_back();
    test_midshift();
    test_rst_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
